// File: rtl/alu8_pkg.sv
// ----------------------------------------------------------------------------
// alu8_pkg
//   Shared definitions for the alu8 execution unit.
//   - WIDTH       : operand/result width (only 8 is supported)
//   - DIV0_RESULT : value produced by unsigned divide when B is zero
//   - op_e        : ALU_Sel opcode encoding
//   Build option: ALU_MULDIV_EN (see alu8_core) enables opcodes 0x2/0x3.
// ----------------------------------------------------------------------------
package alu8_pkg;

    localparam int WIDTH = 8;

    localparam logic [WIDTH-1:0] DIV0_RESULT = 8'hFF;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } op_e;

endpackage

// File: rtl/alu8_core.sv
// ----------------------------------------------------------------------------
// alu8_core
//   Purely combinational operation mux for alu8.
//   Ports:
//     A, B     : byte operands
//     ALU_Sel  : opcode (alu8_pkg::op_e encoding)
//     result   : 8-bit result, truncated
//     carry    : bit 8 of the unsigned sum A+B, for every opcode
//   Build option:
//     ALU_MULDIV_EN defined   -> multiply (low byte) and unsigned divide
//                                (B==0 gives DIV0_RESULT)
//     ALU_MULDIV_EN undefined -> no multiplier/divider; opcodes 0x2/0x3
//                                return 0x00
// ----------------------------------------------------------------------------
module alu8_core
    import alu8_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum_ext;
    op_e            op;

    // Carry is defined from the addition regardless of opcode, so the
    // adder output is shared between the flag and OP_ADD.
    assign sum_ext = {1'b0, A} + {1'b0, B};
    assign carry   = sum_ext[WIDTH];
    assign op      = op_e'(ALU_Sel);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum_ext[WIDTH-1:0];
            OP_SUB:  result = A - B;
`ifdef ALU_MULDIV_EN
            // 8-bit context keeps only the low byte of the product.
            OP_MUL:  result = A * B;
            OP_DIV:  result = (B == '0) ? DIV0_RESULT : (A / B);
`else
            OP_MUL:  result = '0;
            OP_DIV:  result = '0;
`endif
            OP_SHL:  result = {A[WIDTH-2:0], 1'b0};
            OP_SHR:  result = {1'b0, A[WIDTH-1:1]};
            OP_ROL:  result = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  result = {A[0], A[WIDTH-1:1]};
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_NOR:  result = ~(A | B);
            OP_NAND: result = ~(A & B);
            OP_XNOR: result = ~(A ^ B);
            OP_GT:   result = (A > B)  ? 8'h01 : 8'h00;
            OP_EQ:   result = (A == B) ? 8'h01 : 8'h00;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu8.sv
// ----------------------------------------------------------------------------
// alu8
//   8-bit ALU with a one-cycle registered output stage.
//   Ports:
//     clk, rst   : rising-edge clock, asynchronous active-high reset
//     in_valid   : A/B/ALU_Sel are meaningful this cycle
//     A, B       : operands
//     ALU_Sel    : opcode (alu8_pkg::op_e)
//     ALU_Out    : registered result
//     CarryOut   : registered carry (bit 8 of A+B)
//     out_valid  : ALU_Out/CarryOut were loaded on the last edge
//   Build option: ALU_MULDIV_EN (forwarded to alu8_core).
//
//   Handshake: valid-only, no ready. Every cycle with in_valid=1 is accepted
//   unconditionally; exactly one edge later the result is on ALU_Out/CarryOut
//   with out_valid=1 for that one cycle. With in_valid=0 the output
//   registers hold and out_valid is 0, so inputs may be X while idle.
// ----------------------------------------------------------------------------
module alu8 #(
    parameter int WIDTH = alu8_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut,
    output logic             out_valid
);

    logic [WIDTH-1:0] core_result;
    logic             core_carry;

    alu8_core u_core (
        .A       (A),
        .B       (B),
        .ALU_Sel (ALU_Sel),
        .result  (core_result),
        .carry   (core_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_Out   <= '0;
            CarryOut  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ALU_Out  <= core_result;
                CarryOut <= core_carry;
            end
        end
    end

endmodule

// File: tb/tb_alu8.sv
// ----------------------------------------------------------------------------
// tb_alu8
//   Directed self-checking bench for alu8. Expected values are hand-computed
//   constants; mul/div expectations follow the ALU_MULDIV_EN build option.
// ----------------------------------------------------------------------------
module tb_alu8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       out_valid;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    alu8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .ALU_Sel   (alu_sel),
        .ALU_Out   (alu_out),
        .CarryOut  (carry_out),
        .out_valid (out_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] sel);
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        alu_sel  = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] sel);
        @(negedge clk);
        in_valid = 1'b0;
        a        = av;
        b        = bv;
        alu_sel  = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [3:0] sel, input logic [7:0] exp_out, input logic exp_c);
        issue(av, bv, sel);
        check({tag, "_out"}, alu_out, exp_out);
        check({tag, "_carry"}, {7'd0, carry_out}, {7'd0, exp_c});
        check({tag, "_valid"}, {7'd0, out_valid}, 8'h01);
    endtask

    logic [7:0] sweep_exp [16];
    logic [7:0] exp_v;
    logic [7:0] held;

    initial begin
        sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05,
                      8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5,
                      8'hFD, 8'hF7, 8'h01, 8'h00};
`ifndef ALU_MULDIV_EN
        sweep_exp[2] = 8'h00;
        sweep_exp[3] = 8'h00;
`endif

        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        alu_sel  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out",   alu_out, 8'h00);
        check("reset_carry", {7'd0, carry_out}, 8'h00);
        check("reset_valid", {7'd0, out_valid}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Opcode sweep with A=0x0A, B=0x02, back-to-back.
        for (int i = 0; i < 16; i++) exp_q.push_back(sweep_exp[i]);
        for (int i = 0; i < 16; i++) begin
            issue(8'h0A, 8'h02, 4'(i));
            exp_v = exp_q.pop_front();
            check($sformatf("sweep_%0h_out", i), alu_out, exp_v);
            check($sformatf("sweep_%0h_carry", i), {7'd0, carry_out}, 8'h00);
            check($sformatf("sweep_%0h_valid", i), {7'd0, out_valid}, 8'h01);
        end

        // Carry / wrap.
        run_vec("add_wrap", 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1);
        run_vec("sub_big",  8'hF6, 8'h0A, 4'h1, 8'hEC, 1'b1);
        run_vec("gt_big",   8'hF6, 8'h0A, 4'hE, 8'h01, 1'b1);

        // Edge cases.
        run_vec("sub_neg",  8'h02, 8'h0A, 4'h1, 8'hF8, 1'b0);
        run_vec("rol_msb",  8'h81, 8'h00, 4'h6, 8'h03, 1'b0);
        run_vec("ror_lsb",  8'h81, 8'h00, 4'h7, 8'hC0, 1'b0);
        run_vec("shl_ign_b", 8'h81, 8'hFF, 4'h4, 8'h02, 1'b1);
`ifdef ALU_MULDIV_EN
        run_vec("div_zero", 8'h55, 8'h00, 4'h3, 8'hFF, 1'b0);
        run_vec("mul_trunc", 8'h10, 8'h11, 4'h2, 8'h10, 1'b0);
`else
        run_vec("div_zero", 8'h55, 8'h00, 4'h3, 8'h00, 1'b0);
        run_vec("mul_trunc", 8'h10, 8'h11, 4'h2, 8'h00, 1'b0);
`endif
        run_vec("gt_equal", 8'h3C, 8'h3C, 4'hE, 8'h00, 1'b0);
        run_vec("eq_equal", 8'h3C, 8'h3C, 4'hF, 8'h01, 1'b0);

        // Valid gating: outputs hold while inputs churn with in_valid low.
        held = 8'h01;
        for (int i = 0; i < 3; i++) begin
            idle_cycle(8'hFF - 8'(i), 8'hFF, 4'(i));
            check($sformatf("gate%0d_out", i), alu_out, held);
            check($sformatf("gate%0d_carry", i), {7'd0, carry_out}, 8'h00);
            check($sformatf("gate%0d_valid", i), {7'd0, out_valid}, 8'h00);
        end
        run_vec("regate_add", 8'h10, 8'h20, 4'h0, 8'h30, 1'b0);

        // Asynchronous reset mid-stream.
        run_vec("pre_rst", 8'hFF, 8'hFF, 4'h0, 8'hFE, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h0A;
        b        = 8'h02;
        alu_sel  = 4'h0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out",   alu_out, 8'h00);
        check("async_rst_carry", {7'd0, carry_out}, 8'h00);
        check("async_rst_valid", {7'd0, out_valid}, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_valid", {7'd0, out_valid}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_out",   alu_out, 8'h0C);
        check("post_rst_valid", {7'd0, out_valid}, 8'h01);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
